// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer
//   Multi-layer control FSM for the binary NN accelerator. It steps NUM_PE
//   processing elements through cfg_num_layers fully-connected layers back to
//   back. It produces the weight, activation and alpha read addresses, the
//   accumulator load/enable strobes and the activation write-back. The
//   activation RAM is used as two halves that swap roles on every layer.
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   start                       one-cycle run request, honoured only in IDLE
//   stall                       freezes sequencing while high (ignored in IDLE)
//   cfg_num_layers/_in_words/_out_groups   run configuration, latched on start
//   idle, done, err             status: idle level, completion pulse, bad-config pulse
//   layer_idx                   layer currently being processed
//   load, acc_en                PE accumulator load-all and accumulate enable
//   weight_addr_rd              weight RAM read address
//   activation_addr_rd/_wr      activation RAM read/write addresses
//   activation_enb_wr           per-bit activation write enables
//   alpha_addr_rd               alpha (scale) RAM read address
//
// Every output is a flop. The next value of each output is computed together
// with the next sequencer position. A stall sampled on an edge therefore
// blanks the strobes of the following cycle and leaves the addresses held.
// The step that follows the stall resumes from the position already issued.
module bnn_layer_sequencer #(
  parameter int NUM_PE    = 16,
  parameter int WEIGHT_AW = 9,
  parameter int ACT_AW    = 7,
  parameter int ALPHA_AW  = 8,
  parameter int LAYER_W   = 4,
  parameter int PIPE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  input  logic [LAYER_W-1:0]   cfg_num_layers,
  input  logic [ACT_AW-1:0]    cfg_in_words,
  input  logic [ACT_AW-1:0]    cfg_out_groups,
  output logic                 idle,
  output logic                 done,
  output logic                 err,
  output logic [LAYER_W-1:0]   layer_idx,
  output logic [NUM_PE-1:0]    load,
  output logic                 acc_en,
  output logic [WEIGHT_AW-1:0] weight_addr_rd,
  output logic [ACT_AW-1:0]    activation_addr_rd,
  output logic [ACT_AW-1:0]    activation_addr_wr,
  output logic [NUM_PE-1:0]    activation_enb_wr,
  output logic [ALPHA_AW-1:0]  alpha_addr_rd
);

  localparam logic [ACT_AW-1:0] HALF = ACT_AW'(2 ** (ACT_AW - 1));
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  state_t state_r, state_s;
  logic [ACT_AW-1:0]    k_r, k_s, g_r, g_s;
  logic [LAYER_W-1:0]   layer_r, layer_s;
  logic [DW-1:0]        d_r, d_s;
  logic [WEIGHT_AW-1:0] wptr_r, wptr_s;        // next weight address to issue
  logic [ALPHA_AW-1:0]  aptr_r, aptr_s;
  logic [LAYER_W-1:0]   cfg_layers_r, cfg_layers_s;
  logic [ACT_AW-1:0]    cfg_in_r, cfg_in_s, cfg_groups_r, cfg_groups_s;
  logic                 idle_r, idle_s, done_r, done_s, err_r, err_s, acc_en_r, acc_en_s;
  logic [NUM_PE-1:0]    load_r, load_s, enb_r, enb_s;
  logic [WEIGHT_AW-1:0] w_addr_r, w_addr_s;
  logic [ACT_AW-1:0]    act_rd_r, act_rd_s, act_wr_r, act_wr_s;
  logic [ACT_AW-1:0]    in_words_s, rd_base_s, wr_base_s;
  logic                 cfg_bad_s;

  // Layer-dependent decode: words per group and which RAM half is read/written.
  always_comb begin
    in_words_s = (layer_r == LAYER_W'(0)) ? cfg_in_r : cfg_groups_r;
    rd_base_s  = layer_r[0] ? HALF : ACT_AW'(0);
    wr_base_s  = layer_r[0] ? ACT_AW'(0) : HALF;
    cfg_bad_s  = (cfg_num_layers == LAYER_W'(0)) || (cfg_in_words == ACT_AW'(0)) ||
                 (cfg_out_groups == ACT_AW'(0)) || (cfg_in_words > HALF) ||
                 (cfg_out_groups > HALF);
  end

  // Next sequencer position and next output values.
  always_comb begin
    state_s      = state_r;
    k_s          = k_r;
    g_s          = g_r;
    layer_s      = layer_r;
    d_s          = d_r;
    wptr_s       = wptr_r;
    aptr_s       = aptr_r;
    cfg_layers_s = cfg_layers_r;
    cfg_in_s     = cfg_in_r;
    cfg_groups_s = cfg_groups_r;
    idle_s       = 1'b0;
    done_s       = 1'b0;
    err_s        = 1'b0;
    acc_en_s     = 1'b0;
    load_s       = {NUM_PE{1'b0}};
    enb_s        = {NUM_PE{1'b0}};
    w_addr_s     = w_addr_r;
    act_rd_s     = act_rd_r;
    act_wr_s     = ACT_AW'(0);
    case (state_r)
      S_IDLE: begin
        idle_s = 1'b1;
        if (start) begin
          if (cfg_bad_s) begin
            err_s = 1'b1;
          end else begin
            cfg_layers_s = cfg_num_layers;
            cfg_in_s     = cfg_in_words;
            cfg_groups_s = cfg_out_groups;
            state_s      = S_COMPUTE;
            k_s          = ACT_AW'(0);
            g_s          = ACT_AW'(0);
            layer_s      = LAYER_W'(0);
            d_s          = DW'(0);
            aptr_s       = ALPHA_AW'(0);
            w_addr_s     = WEIGHT_AW'(0);
            wptr_s       = WEIGHT_AW'(1);
            act_rd_s     = ACT_AW'(0);
            load_s       = {NUM_PE{1'b1}};
            acc_en_s     = 1'b1;
            idle_s       = 1'b0;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_COMPUTE: begin
        if (stall) begin
          state_s = S_COMPUTE;
        end else if (k_r == in_words_s - ACT_AW'(1)) begin
          state_s = S_DRAIN;
          d_s     = DW'(0);
        end else begin
          k_s      = k_r + ACT_AW'(1);
          act_rd_s = rd_base_s + k_r + ACT_AW'(1);
          w_addr_s = wptr_r;
          wptr_s   = wptr_r + WEIGHT_AW'(1);
          acc_en_s = 1'b1;
        end
      end
      S_DRAIN: begin
        if (stall) begin
          state_s = S_DRAIN;
        end else if (d_r == DRAIN_LAST) begin
          state_s  = S_WRITE;
          act_wr_s = wr_base_s + g_r;
          enb_s    = {NUM_PE{1'b1}};
        end else begin
          d_s = d_r + DW'(1);
        end
      end
      S_WRITE: begin
        if (stall) begin
          act_wr_s = act_wr_r;   // stay on the write address, enables stay off
        end else begin
          aptr_s = aptr_r + ALPHA_AW'(1);
          if ((g_r != cfg_groups_r - ACT_AW'(1)) || (layer_r != cfg_layers_r - LAYER_W'(1))) begin
            // Next group: same layer, or the first group of the next layer
            // reading the half that was just written.
            state_s  = S_COMPUTE;
            k_s      = ACT_AW'(0);
            w_addr_s = wptr_r;
            wptr_s   = wptr_r + WEIGHT_AW'(1);
            load_s   = {NUM_PE{1'b1}};
            acc_en_s = 1'b1;
            if (g_r != cfg_groups_r - ACT_AW'(1)) begin
              g_s      = g_r + ACT_AW'(1);
              act_rd_s = rd_base_s;
            end else begin
              g_s      = ACT_AW'(0);
              layer_s  = layer_r + LAYER_W'(1);
              act_rd_s = wr_base_s;
            end
          end else begin
            state_s = S_IDLE;
            done_s  = 1'b1;
            idle_s  = 1'b1;
          end
        end
      end
      default: begin
        state_s = S_IDLE;
        idle_s  = 1'b1;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      k_r          <= ACT_AW'(0);
      g_r          <= ACT_AW'(0);
      layer_r      <= LAYER_W'(0);
      d_r          <= DW'(0);
      wptr_r       <= WEIGHT_AW'(0);
      aptr_r       <= ALPHA_AW'(0);
      cfg_layers_r <= LAYER_W'(0);
      cfg_in_r     <= ACT_AW'(0);
      cfg_groups_r <= ACT_AW'(0);
      idle_r       <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      acc_en_r     <= 1'b0;
      load_r       <= {NUM_PE{1'b0}};
      enb_r        <= {NUM_PE{1'b0}};
      w_addr_r     <= WEIGHT_AW'(0);
      act_rd_r     <= ACT_AW'(0);
      act_wr_r     <= ACT_AW'(0);
    end else begin
      state_r      <= state_s;
      k_r          <= k_s;
      g_r          <= g_s;
      layer_r      <= layer_s;
      d_r          <= d_s;
      wptr_r       <= wptr_s;
      aptr_r       <= aptr_s;
      cfg_layers_r <= cfg_layers_s;
      cfg_in_r     <= cfg_in_s;
      cfg_groups_r <= cfg_groups_s;
      idle_r       <= idle_s;
      done_r       <= done_s;
      err_r        <= err_s;
      acc_en_r     <= acc_en_s;
      load_r       <= load_s;
      enb_r        <= enb_s;
      w_addr_r     <= w_addr_s;
      act_rd_r     <= act_rd_s;
      act_wr_r     <= act_wr_s;
    end
  end

  assign idle               = idle_r;
  assign done               = done_r;
  assign err                = err_r;
  assign layer_idx          = layer_r;
  assign load               = load_r;
  assign acc_en             = acc_en_r;
  assign weight_addr_rd     = w_addr_r;
  assign activation_addr_rd = act_rd_r;
  assign activation_addr_wr = act_wr_r;
  assign activation_enb_wr  = enb_r;
  assign alpha_addr_rd      = aptr_r;

endmodule
